dmem_sized: RTL and testbench
=============================

# dmem_sized

Parametrised data memory for the single-cycle/pipelined RISC-V core, replacing the fixed 256-word word-only DMEM. Supports RV32I sub-word loads and stores (byte/half/word, signed/unsigned) with per-byte write enables and misalignment detection. Uses a valid/ready request channel with a registered, one-cycle response, which makes it block-RAM friendly. Clearing after reset is done by a sequential sweep, not an asynchronous array reset.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, ≥ 2
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts the request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  3  RV32I funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned (SB uses [7:0], SH uses [15:0])
- rsp_valid  out  1  response for the request accepted in the previous cycle
- rsp_rdata  out  32  load result after extension; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal req_size
- init_done  out  1  clear sweep complete

## Operation
- Reset is clk on clk, with rst_n asynchronous and active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, state=INIT, sweep counter=0.
- FSM states: INIT and RUN.
  - INIT: writes 0 to word[counter] each cycle and increments the counter. req_ready=0.
  - After the word DEPTH-1 is written: go to RUN and set init_done=1.
  - RUN: req_ready=1 permanently.
- Asserting rst_n at any time, including mid-sweep or mid-response, returns the block to INIT with the counter at 0. Any pending response is dropped.
- Word index is req_addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Alignment rules:
  - Half accesses need addr[0]=0.
  - Word accesses need addr[1:0]=00.
  - Byte accesses are always aligned.
- Illegal req_size:
  - Loads: 011, 110, 111.
  - Stores: any size other than 000, 001, 010.
- Error case (misaligned or illegal): no memory write, rsp_err=1, rsp_rdata=0.
- Stores write only the byte lanes they cover:
  - SB writes lane addr[1:0].
  - SH writes lanes {2·addr[1]+1, 2·addr[1]}.
  - SW writes all four lanes.
  - Untouched lanes keep their value.
- Loads select the byte or half at addr[1:0]:
  - LB and LH sign-extend from bit 7 or bit 15.
  - LBU and LHU zero-extend.
  - LW returns the word as is.
- Stores also produce a response: rsp_valid=1, rsp_rdata=0, and rsp_err as applicable.

## Timing
- Accept: a request is accepted on a rising edge when req_valid && req_ready.
- Response: rsp_valid is registered and high exactly one cycle after acceptance, for one cycle per request. A load's data is valid with it.
- Throughput: one request per cycle with no bubbles. There is no backpressure on the response path.
- Store commit: the write commits on the accepting edge.
  - A load accepted in the next cycle sees the new data.
  - There is no same-cycle read/write conflict, because only one request is accepted per cycle.
- When no request is accepted, rsp_valid=0 and rsp_rdata/rsp_err return to 0.
- INIT lasts exactly DEPTH cycles after reset release. The first request is accepted at cycle DEPTH, counted from the first edge after rst_n rises.
- Requests presented during INIT are not accepted. The requester must hold them.

## Structure
- Package dmem_pkg holds:
  - enum mem_size_e with the funct3 codes (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
  - enum dmem_state_e {INIT, RUN}
  - function is_misaligned(size, addr[1:0])
- Sub-module dmem_load_align is combinational. It takes the raw word, addr[1:0] and size, and outputs the extended 32-bit load data. It is reused by the LSU.
- Storage is one array of DEPTH×32 bits with byte-lane writes and a synchronous read. It has no reset on the array itself.

## Test plan
- Reset/init: release rst_n with DEPTH=16.
  - Required: req_ready=0 for 16 cycles, then req_ready=1 and init_done=1.
  - Required: LW of every address 0x00–0x3C returns 0.
- Word store/load: SW 0xDEADBEEF to 0x08, then LW 0x08 on the next cycle.
  - Required: rsp_rdata=0xDEADBEEF, rsp_err=0, with a one-cycle latency on each response.
- Sub-word and extension: after the step above, SB 0x80 to 0x09, then SH 0x1234 to 0x0A.
  - Required: LW 0x08 gives 0x123480EF.
  - Required: LB 0x09 gives 0xFFFFFF80, LBU 0x09 gives 0x00000080, LH 0x0A gives 0x00001234.
- Misaligned/illegal: LW 0x0A, SH 0x05, and a load with req_size=011.
  - Required: each returns rsp_err=1 and rsp_rdata=0, and memory is unchanged (LW 0x08 still 0x123480EF).
- Wrap and back-to-back: with DEPTH=16, SW 0x11111111 to 0x40, then LW 0x00 in consecutive cycles.
  - Required: the load returns 0x11111111.
  - Required: continuous req_valid gives one rsp_valid per cycle.
- Reset mid-sweep: assert rst_n low at INIT cycle 5, then release.
  - Required: outputs return immediately to their reset values.
  - Required: a full 16-cycle INIT follows, and the data written before reset reads as 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the sized data memory
//
// Holds the funct3 size codes, the init/run state encoding and the
// alignment check used by the memory and the LSU.
package dmem_pkg;

    // Load and store share funct3 codes; unsigned variants exist only for loads.
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    // Alignment only; illegal size codes are rejected separately.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_H, SZ_HU: return addr_lo[0];
            SZ_W:        return |addr_lo;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects and extends load data from a raw memory word
//
// Ports:
//   word  in  32  raw 32-bit memory word
//   off   in  2   byte offset within the word (addr[1:0])
//   size  in  3   load funct3 code
//   data  out 32  selected byte/half/word, sign- or zero-extended
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[{off, 3'b000} +: 8];
        // Halves are aligned, so only off[1] picks the half.
        sel_half = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    data = {{24{sel_byte[7]}}, sel_byte};
            SZ_H:    data = {{16{sel_half[15]}}, sel_half};
            SZ_BU:   data = {24'd0, sel_byte};
            SZ_HU:   data = {16'd0, sel_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - byte-addressable data memory with sub-word access and clear sweep
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only after the sweep)
//   req_we, req_size, req_addr,     store flag, funct3 size, byte address,
//   req_wdata                       LSB-aligned store data
//   rsp_valid, rsp_rdata, rsp_err   one-cycle registered response
//   init_done                       clear sweep finished
module dmem_sized
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);

    logic [31:0] mem [DEPTH];

    dmem_state_e      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             init_done_q, init_done_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_load_q, rsp_load_d;
    logic [2:0]       rsp_size_q, rsp_size_d;
    logic [1:0]       rsp_off_q, rsp_off_d;
    logic [31:0]      rd_word_q;

    logic             accept;
    logic             illegal;
    logic             err;
    logic [IDX_W-1:0] idx;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [IDX_W-1:0] mem_widx;
    logic [31:0]      mem_wdata;
    logic [31:0]      load_data;
    logic             unused_addr_bits;

    // Upper address bits are ignored: accesses wrap modulo DEPTH*4 bytes.
    assign idx              = req_addr[IDX_W+1:2];
    assign unused_addr_bits = ^req_addr[31:IDX_W+2];

    assign accept  = req_valid && req_ready_q;
    assign illegal = req_we ? (req_size > 3'b010)
                            : (req_size == 3'b011 || req_size[2:1] == 2'b11);
    assign err     = illegal || is_misaligned(req_size, req_addr[1:0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        init_done_d = init_done_q;
        mem_we      = 1'b0;
        mem_be      = 4'h0;
        mem_widx    = idx;
        mem_wdata   = 32'd0;

        if (state_q == INIT) begin
            // Sweep: zero one word per cycle; the array itself has no reset.
            mem_we   = 1'b1;
            mem_be   = 4'hF;
            mem_widx = cnt_q;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d     = RUN;
                req_ready_d = 1'b1;
                init_done_d = 1'b1;
            end
        end else if (accept && req_we && !err) begin
            mem_we = 1'b1;
            // Replicate the data across lanes; byte enables pick what lands.
            case (req_size)
                SZ_B: begin
                    mem_be    = 4'b0001 << req_addr[1:0];
                    mem_wdata = {4{req_wdata[7:0]}};
                end
                SZ_H: begin
                    mem_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    mem_be    = 4'hF;
                    mem_wdata = req_wdata;
                end
            endcase
        end

        rsp_valid_d = accept;
        rsp_err_d   = accept && err;
        rsp_load_d  = accept && !req_we && !err;
        rsp_size_d  = req_size;
        rsp_off_d   = req_addr[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_size_q  <= 3'b000;
            rsp_off_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
            rsp_size_q  <= rsp_size_d;
            rsp_off_q   <= rsp_off_d;
        end
    end

    // Block-RAM style storage: byte-lane writes, registered read, no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        if (accept && !req_we) begin
            rd_word_q <= mem[idx];
        end
    end

    dmem_load_align u_align (
        .word (rd_word_q),
        .off  (rsp_off_q),
        .size (rsp_size_q),
        .data (load_data)
    );

    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // Stores, errors and idle cycles all report zero data.
    assign rsp_rdata = rsp_load_q ? load_data : 32'd0;

endmodule

// File: tb/tb_dmem_sized.sv
// tb/tb_dmem_sized.sv - self-checking bench for dmem_sized
module tb_dmem_sized;

    localparam int DEPTH = 16;
    localparam int NBYTES = DEPTH * 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mbytes [NBYTES];

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [16];

    dmem_sized #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-array reference: legality from funct3 rules, data assembled byte by byte.
    task automatic model_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err, output logic [31:0] rd);
        int a, n;
        logic bad;
        logic [31:0] val;
        a = int'(addr % NBYTES);
        n = 1 << size[1:0];
        bad = (size[1:0] == 2'b11) || (size == 3'b110) || (we && size[2]);
        err = bad || ((a % n) != 0);
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mbytes[a + i] = wdata[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++) val = val | (32'(mbytes[a + i]) << (8 * i));
                if (!size[2] && n < 4 && val[8*n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
                rd = val;
            end
        end
    endtask

    // One clock cycle: present request at negedge, check its response at the next negedge.
    task automatic run_req(input string name, input logic v, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rd);
        req_valid = v;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'(v));
        chk({name, "_rsp_err"}, 32'(rsp_err), 32'(v && exp_err));
        chk({name, "_rsp_rdata"}, rsp_rdata, v ? exp_rd : 32'd0);
    endtask

    // Entered at a negedge with rst_n low; leaves at the negedge where ready first rises.
    task automatic do_init();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b010;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rst_n     = 1'b1;
        chk("init_ready_first", 32'(req_ready), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("init_ready_low", 32'(req_ready), 32'd0);
            chk("init_done_low", 32'(init_done), 32'd0);
            chk("init_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("init_ready_high", 32'(req_ready), 32'd1);
        chk("init_done_high", 32'(init_done), 32'd1);
        chk("init_last_no_rsp", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({name, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({name, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    task automatic lw_all_zero(input string name);
        for (int a = 0; a < NBYTES; a += 4) run_req(name, 1'b1, 1'b0, 3'b010, 32'(a), 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic        m_err;
        logic [31:0] m_rd;
        logic        v, we;
        logic [2:0]  size;
        logic [31:0] addr, wdata;

        vecs[0]  = '{1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'b010, 32'h08, 32'h0,       1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 3'b000, 32'h09, 32'h00000080, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 3'b001, 32'h0A, 32'h00001234, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 3'b010, 32'h08, 32'h0,       1'b0, 32'h123480EF};
        vecs[5]  = '{1'b0, 3'b000, 32'h09, 32'h0,       1'b0, 32'hFFFFFF80};
        vecs[6]  = '{1'b0, 3'b100, 32'h09, 32'h0,       1'b0, 32'h00000080};
        vecs[7]  = '{1'b0, 3'b001, 32'h0A, 32'h0,       1'b0, 32'h00001234};
        vecs[8]  = '{1'b0, 3'b010, 32'h0A, 32'h0,       1'b1, 32'h0};
        vecs[9]  = '{1'b1, 3'b001, 32'h05, 32'hAAAAAAAA, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h08, 32'h0,       1'b1, 32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h08, 32'h55555555, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 3'b010, 32'h08, 32'h0,       1'b0, 32'h123480EF};
        vecs[13] = '{1'b1, 3'b010, 32'h40, 32'h11111111, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 3'b010, 32'h00, 32'h0,       1'b0, 32'h11111111};
        vecs[15] = '{1'b0, 3'b101, 32'h08, 32'h0,       1'b0, 32'h000080EF};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        do_init();
        lw_all_zero("lw_after_init");

        // Directed vectors issued back to back.
        foreach (vecs[i]) begin
            model_access(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, m_err, m_rd);
            run_req($sformatf("vec%0d", i), 1'b1, vecs[i].we, vecs[i].size, vecs[i].addr,
                    vecs[i].wdata, vecs[i].err, vecs[i].rdata);
        end

        // Random traffic against the byte-array model, with idle gaps.
        for (int i = 0; i < 400; i++) begin
            v     = ($urandom_range(0, 4) != 0);
            we    = $urandom_range(0, 1) == 1;
            size  = 3'($urandom_range(0, 7));
            addr  = $urandom;
            wdata = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            m_err = 1'b0;
            m_rd  = 32'h0;
            if (v) model_access(we, size, addr, wdata, m_err, m_rd);
            run_req("rand", v, we, size, addr, wdata, m_err, m_rd);
        end

        // Reset while a response is on the outputs: must drop at once.
        model_access(1'b0, 3'b010, 32'h08, 32'h0, m_err, m_rd);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b010;
        req_addr  = 32'h08;
        @(posedge clk);
        #1;
        chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pre_reset_rsp_rdata", rsp_rdata, m_rd);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_rsp");
        @(negedge clk);
        do_init();
        run_req("sw_before_reset", 1'b1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0);
        run_req("lw_before_reset", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D);

        // Reset in the middle of the clear sweep.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_sweep");
        @(negedge clk);
        do_init();
        lw_all_zero("lw_after_resweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
